// File: rtl/banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores_param
// Description : NREG x XLEN register bank with x0 hardwired to zero, two
//               combinational read ports (optional write bypass), one
//               write-back port with 4-way source select, and a valid/ready
//               dump engine that streams every register with its index.
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registradores_param #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [1:0]      wb_sel,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] pc4_data,
  input  logic [XLEN-1:0] imm_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            dump_start,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy,
  output logic            dump_done
);

  localparam logic [0:0]    c_st_idle = 1'b0;
  localparam logic [0:0]    c_st_send = 1'b1;
  localparam logic [AW-1:0] c_last    = AW'(NREG - 1);

  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_regs [NREG];
  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_next_idx;
  logic [XLEN-1:0] r_data;
  logic            r_done;

  // Write-back source mux
  always_comb begin
    w_wdata = alu_data;
    case (wb_sel)
      2'b00:   w_wdata = alu_data;
      2'b01:   w_wdata = mem_data;
      2'b10:   w_wdata = pc4_data;
      default: w_wdata = imm_data;
    endcase
  end

  // Register storage; entry 0 is a constant zero, never written
  generate
    for (genvar g = 0; g < NREG; g++) begin : g_regs
      if (g == 0) begin : g_zero
        assign w_regs[g] = '0;
      end else begin : g_reg
        logic [XLEN-1:0] r_q;
        // Capture write-back data when this register is the destination
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)
            r_q <= '0;
          else if (wr_en && (rd == AW'(g)))
            r_q <= w_wdata;
        end
        assign w_regs[g] = r_q;
      end
    end
  endgenerate

  // Read port 1: zero for x0, optional same-cycle forwarding, else storage
  always_comb begin
    rdata1 = w_regs[rs1];
    if (rs1 == '0)
      rdata1 = '0;
    else if ((BYPASS != 0) && wr_en && (rd == rs1))
      rdata1 = w_wdata;
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rdata2 = w_regs[rs2];
    if (rs2 == '0)
      rdata2 = '0;
    else if ((BYPASS != 0) && wr_en && (rd == rs2))
      rdata2 = w_wdata;
  end

  // Dump FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= c_st_idle;
    else
      r_state <= w_state_nxt;
  end

  // Dump FSM next state: start only from IDLE, leave SEND on last accepted beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (dump_start) w_state_nxt = c_st_send;
      c_st_send: if (dump_ready && (r_idx == c_last)) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Dump FSM outputs: a beat is offered for the whole of SEND
  always_comb begin
    dump_valid = (r_state == c_st_send);
    dump_busy  = (r_state == c_st_send);
  end

  assign w_next_idx = r_idx + AW'(1);

  // Beat index/data and completion pulse; data is loaded once per beat so a
  // stalled beat keeps its snapshot even if that register is rewritten
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (dump_start) begin
            r_idx  <= '0;
            r_data <= w_regs[0];
          end
        end
        default: begin
          if (dump_ready) begin
            if (r_idx == c_last) begin
              r_idx  <= '0;
              r_data <= '0;
              r_done <= 1'b1;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= (wr_en && (rd == w_next_idx)) ? w_wdata : w_regs[w_next_idx];
            end
          end
        end
      endcase
    end
  end

  assign dump_idx  = r_idx;
  assign dump_data = r_data;
  assign dump_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registradores_param
// Description : Directed self-checking bench for banco_registradores_param;
//               one instance with write bypass, one without.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registradores_param;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wb_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] alu_data, mem_data, pc4_data, imm_data;
  logic        dump_start, dump_ready;
  logic [31:0] rdata1, rdata2, dump_data;
  logic        dump_valid, dump_busy, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] rdata1_nb, rdata2_nb, dump_data_nb;
  logic        dump_valid_nb, dump_busy_nb, dump_done_nb;
  logic [4:0]  dump_idx_nb;

  int cnt_cmp = 0;
  int cnt_err = 0;

  banco_registradores_param #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wb_sel(wb_sel), .rd(rd),
    .alu_data(alu_data), .mem_data(mem_data), .pc4_data(pc4_data), .imm_data(imm_data),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  banco_registradores_param #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wb_sel(wb_sel), .rd(rd),
    .alu_data(alu_data), .mem_data(mem_data), .pc4_data(pc4_data), .imm_data(imm_data),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1_nb), .rdata2(rdata2_nb),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid_nb),
    .dump_idx(dump_idx_nb), .dump_data(dump_data_nb), .dump_busy(dump_busy_nb), .dump_done(dump_done_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cnt_cmp++;
    if (got !== exp) begin
      cnt_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat data for the second dump: beat 7 keeps its pre-stall
  // value, beat 8 picks up the write made while beat 7 was accepted
  function automatic logic [31:0] exp_d2(input int b);
    if (b == 7)      return 32'h77;
    else if (b == 8) return 32'h888;
    else             return 32'(b * 32'h11);
  endfunction

  int  beat;
  int  cyc;
  bit  seen7;
  bit  acc;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wb_sel = 2'b00; rd = '0; rs1 = 5'd5; rs2 = 5'd0;
    alu_data = '0; mem_data = '0; pc4_data = '0; imm_data = '0;
    dump_start = 1'b0; dump_ready = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst rdata1", rdata1, 32'h0);
    chk("rst rdata2", rdata2, 32'h0);
    chk("rst valid", {31'b0, dump_valid}, 32'h0);
    chk("rst busy", {31'b0, dump_busy}, 32'h0);
    chk("rst done", {31'b0, dump_done}, 32'h0);
    chk("rst idx", {27'b0, dump_idx}, 32'h0);
    chk("rst data", dump_data, 32'h0);
    rst = 1'b1;

    // ALU write with same-cycle read of the destination
    tick();
    wr_en = 1'b1; rd = 5'd3; wb_sel = 2'b00; alu_data = 32'h12345678; rs1 = 5'd3;
    #1;
    chk("bypass rdata1", rdata1, 32'h12345678);
    chk("nobypass rdata1", rdata1_nb, 32'h0);
    tick();
    wr_en = 1'b0; #1;
    chk("r3 after wr", rdata1, 32'h12345678);
    chk("r3 after wr nb", rdata1_nb, 32'h12345678);

    // Write to x0 is discarded
    wr_en = 1'b1; rd = 5'd0; wb_sel = 2'b01; mem_data = 32'hDEADBEEF; rs1 = 5'd0;
    #1;
    chk("x0 same cycle", rdata1, 32'h0);
    tick();
    wr_en = 1'b0; #1;
    chk("x0 after wr", rdata1, 32'h0);
    chk("x0 after wr nb", rdata1_nb, 32'h0);

    // PC+4 and immediate sources
    wr_en = 1'b1; wb_sel = 2'b10; pc4_data = 32'h44; rd = 5'd1;
    tick();
    wb_sel = 2'b11; imm_data = 32'hABC00000; rd = 5'd2;
    tick();
    wr_en = 1'b0; rs1 = 5'd1; rs2 = 5'd2; #1;
    chk("r1 pc4", rdata1, 32'h44);
    chk("r2 imm", rdata2, 32'hABC00000);
    chk("r2 imm nb", rdata2_nb, 32'hABC00000);

    // Asynchronous reset between clock edges
    #1 rst = 1'b0;
    #1;
    chk("async rst r1", rdata1, 32'h0);
    chk("async rst r2", rdata2, 32'h0);
    chk("async rst r2 nb", rdata2_nb, 32'h0);
    rst = 1'b1;

    // Preload regs[k] = k*0x11
    for (int k = 1; k < 32; k++) begin
      tick();
      wr_en = 1'b1; wb_sel = 2'b00; rd = 5'(k); alu_data = 32'(k * 32'h11);
    end
    tick();
    wr_en = 1'b0;

    // Dump 1: always ready
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      #1;
      chk($sformatf("d1 valid b%0d", b), {31'b0, dump_valid}, 32'h1);
      chk($sformatf("d1 idx b%0d", b), {27'b0, dump_idx}, 32'(b));
      chk($sformatf("d1 data b%0d", b), dump_data, 32'(b * 32'h11));
      chk($sformatf("d1 done b%0d", b), {31'b0, dump_done}, 32'h0);
      tick();
    end
    #1;
    chk("d1 done pulse", {31'b0, dump_done}, 32'h1);
    chk("d1 busy end", {31'b0, dump_busy}, 32'h0);
    chk("d1 valid end", {31'b0, dump_valid}, 32'h0);
    chk("d1 idx end", {27'b0, dump_idx}, 32'h0);
    tick(); #1;
    chk("d1 done single", {31'b0, dump_done}, 32'h0);

    // Dump 2: random backpressure, stalled-beat write, start while busy
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    beat = 0; cyc = 0; seen7 = 1'b0;
    while (beat < 32 && cyc < 400) begin
      #1;
      chk($sformatf("d2 valid b%0d", beat), {31'b0, dump_valid}, 32'h1);
      chk($sformatf("d2 idx b%0d", beat), {27'b0, dump_idx}, 32'(beat));
      chk($sformatf("d2 data b%0d", beat), dump_data, exp_d2(beat));
      wr_en = 1'b0; dump_start = 1'b0;
      dump_ready = 1'($urandom_range(0, 1));
      if (beat == 7 && !seen7) begin
        dump_ready = 1'b0; wr_en = 1'b1; wb_sel = 2'b00; rd = 5'd7; alu_data = 32'h777;
        seen7 = 1'b1;
      end else if (beat == 7) begin
        dump_ready = 1'b1; wr_en = 1'b1; wb_sel = 2'b00; rd = 5'd8; alu_data = 32'h888;
      end
      if (beat == 10) dump_start = 1'b1;
      acc = dump_ready;
      tick();
      if (acc) beat++;
      cyc++;
    end
    wr_en = 1'b0; dump_start = 1'b0;
    chk("d2 beat count", 32'(beat), 32'd32);
    #1;
    chk("d2 done pulse", {31'b0, dump_done}, 32'h1);
    chk("d2 busy end", {31'b0, dump_busy}, 32'h0);
    tick(); #1;
    chk("d2 no restart", {31'b0, dump_valid}, 32'h0);
    chk("d2 done single", {31'b0, dump_done}, 32'h0);
    rs1 = 5'd7; rs2 = 5'd8; #1;
    chk("r7 new", rdata1, 32'h777);
    chk("r8 new", rdata2, 32'h888);

    // Dump 3: reset in the middle aborts without a done pulse
    tick();
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (15) tick();
    #1;
    chk("d3 idx 15", {27'b0, dump_idx}, 32'd15);
    #1 rst = 1'b0;
    #1;
    chk("d3 abort valid", {31'b0, dump_valid}, 32'h0);
    chk("d3 abort busy", {31'b0, dump_busy}, 32'h0);
    chk("d3 abort idx", {27'b0, dump_idx}, 32'h0);
    chk("d3 abort r7", rdata1, 32'h0);
    #1 rst = 1'b1;
    tick(); #1;
    chk("d3 no done a", {31'b0, dump_done}, 32'h0);
    chk("d3 idle valid", {31'b0, dump_valid}, 32'h0);
    tick(); #1;
    chk("d3 no done b", {31'b0, dump_done}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
    $finish;
  end

endmodule
`default_nettype wire
